// File: rtl/psa_acc.sv
// rtl/psa_acc.sv - saturating packed-nibble burst accumulator with valid/ready result handshake
// Optional per-lane saturation event counters: define PSA_ACC_SATCNT_EN.
module psa_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [3:0]       out_err,
  output logic [CNT_W-1:0] out_count,
  output logic [15:0]      sat_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [3:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lane_sum;
  logic [3:0]       lane_ovf;
  logic             accept;
  logic             clear;

  // Bit 3 of the 4-bit wrap sum equals bit 3 of the sign-extended 5-bit sum.
  function automatic logic [4:0] lane_add(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    logic       ovf;
    s   = a + b;
    ovf = (a[3] == b[3]) && (s[3] != a[3]);
    if (ovf) return {1'b1, (a[3] ? 4'b1000 : 4'b0111)};
    return {1'b0, s};
  endfunction

  always_comb begin
    lane_sum = '0;
    lane_ovf = '0;
    for (int k = 0; k < 4; k++) begin
      {lane_ovf[k], lane_sum[4*k +: 4]} = lane_add(acc_q[4*k +: 4], in_data[4*k +: 4]);
    end
  end

  assign accept = in_valid && in_ready;
  // clr only matters outside DONE; in DONE the result clears on the output handshake.
  assign clear  = (state_q == DONE) ? out_ready : clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (clr)         state_d = IDLE;
        else if (accept) state_d = in_last ? DONE : ACC;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != DONE) && !clr;
    out_valid = (state_q == DONE);
  end

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      err_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = lane_sum;
      err_d = err_q | lane_ovf;
      if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_data  = acc_q;
  assign out_err   = err_q;
  assign out_count = cnt_q;

`ifdef PSA_ACC_SATCNT_EN
  logic [15:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (clear) begin
      sat_d = '0;
    end else if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_ovf[k] && (sat_q[4*k +: 4] != 4'hF))
          sat_d[4*k +: 4] = sat_q[4*k +: 4] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end

  assign sat_cnt = sat_q;
`else
  assign sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_psa_acc.sv
// tb/tb_psa_acc.sv - directed self-checking bench for psa_acc
module tb_psa_acc;

  localparam int CNT_W = 8;

`ifdef PSA_ACC_SATCNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_data;
  logic [3:0]       out_err;
  logic [CNT_W-1:0] out_count;
  logic [15:0]      sat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  psa_acc #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .out_count(out_count),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] d, input logic [3:0] e,
                              input logic [CNT_W-1:0] c, input logic [15:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".err"},   32'(out_err),   32'(e));
    check({tag, ".count"}, 32'(out_count), 32'(c));
    check({tag, ".sat"},   32'(sat_cnt),   SAT_EN ? 32'(s) : 32'd0);
  endtask

  task automatic finish_handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.data",  32'(out_data),  32'd0);
    check("reset.err",   32'(out_err),   32'd0);
    check("reset.count", 32'(out_count), 32'd0);
    check("reset.sat",   32'(sat_cnt),   32'd0);
    check("reset.ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'h1111, 1'b0);
    send(16'h1111, 1'b0);
    check("basic.mid_valid", 32'(out_valid), 32'd0);
    send(16'h1111, 1'b1);
    check_result("basic", 16'h3333, 4'h0, 8'd3, 16'h0000);
    finish_handshake("basic");

    send(16'h7777, 1'b0);
    send(16'h1111, 1'b1);
    check_result("possat", 16'h7777, 4'hF, 8'd2, 16'h1111);
    finish_handshake("possat");

    send(16'h8888, 1'b0);
    send(16'hFFFF, 1'b1);
    check_result("negsat", 16'h8888, 4'hF, 8'd2, 16'h1111);
    finish_handshake("negsat");

    send(16'h7F81, 1'b0);
    send(16'h1111, 1'b1);
    check_result("mixed", 16'h7092, 4'b1000, 8'd2, 16'h1000);
    finish_handshake("mixed");

    // Backpressure, with a beat waiting during DONE that must not be taken early.
    out_ready = 1'b0;
    send(16'h0123, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h0004;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.data",  32'(out_data),  32'h0123);
      check("bp.ready", 32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.hs_valid", 32'(out_valid), 32'd0);
    check("bp.hs_ready", 32'(in_ready),  32'd1);
    check("bp.hs_acc",   32'(out_data),  32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp.next_data",  32'(out_data),  32'h0004);
    check("bp.next_count", 32'(out_count), 32'd1);
    send(16'h0000, 1'b1);
    check_result("bp.next", 16'h0004, 4'h0, 8'd2, 16'h0000);
    finish_handshake("bp.next");

    // Beat counter saturates at all-ones.
    for (int i = 0; i < 260; i++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    check_result("cntsat", 16'h0000, 4'h0, 8'hFF, 16'h0000);
    finish_handshake("cntsat");

    // Abort with clr; a beat offered alongside clr is dropped.
    send(16'h2222, 1'b0);
    send(16'h2222, 1'b0);
    check("clr.pre_data", 32'(out_data), 32'h4444);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h2222;
    #1;
    check("clr.ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr.data",  32'(out_data),  32'd0);
    check("clr.count", 32'(out_count), 32'd0);
    out_ready = 1'b0;
    send(16'h0001, 1'b1);
    check_result("after_clr", 16'h0001, 4'h0, 8'd1, 16'h0000);

    // Asynchronous reset while DONE is held.
    rst_n = 1'b0;
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data",  32'(out_data),  32'd0);
    check("rst.err",   32'(out_err),   32'd0);
    check("rst.count", 32'(out_count), 32'd0);
    check("rst.sat",   32'(sat_cnt),   32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst.after_valid", 32'(out_valid), 32'd0);
    check("rst.after_ready", 32'(in_ready),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/psa_acc.md
# psa_acc

Saturating packed-nibble accumulator sitting directly downstream of the 16-bit parallel sub-word adder (PADDSB) datapath. It consumes a stream of 16-bit vectors, each holding four signed 4-bit lanes. It sums each lane into a saturating 4-bit accumulator over a burst terminated by a last flag. It then presents the per-lane result, the sticky per-lane overflow flags and the beat count through a valid/ready output handshake.

## Interface
- CNT_W, 8, width of the beat counter; the counter saturates at 2^CNT_W-1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  16  four signed 4-bit lanes; lane k = in_data[4k+3:4k]
- in_last  in  1  marks the final beat of a burst
- clr  in  1  synchronous burst abort / clear
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  16  per-lane saturated accumulation
- out_err  out  4  sticky per-lane saturation flags
- out_count  out  CNT_W  beats accepted in the burst
- sat_cnt  out  16  per-lane 4-bit saturation event counters; see Configuration

## Operation
- One clock (clk); reset is asynchronous and active-low (rst_n).
- States:
  - IDLE: no beats held.
  - ACC: at least one beat accepted, no last yet.
  - DONE: result held.
- Reset: state IDLE, accumulator 0x0000, out_err 0, out_count 0, sat_cnt 0, out_valid 0. out_data reflects the accumulator, so it reads 0x0000.
- in_ready = (state != DONE) && !clr. A beat is accepted when in_valid && in_ready.
- Lane add: sign-extend acc lane and in lane to 5 bits and add.
  - Overflow when both operand sign bits are equal and differ from bit 3 of the sum.
  - Positive overflow (operands non-negative) yields 4'b0111.
  - Negative overflow yields 4'b1000.
  - Otherwise the result is sum[3:0].
  - Each lane is independent; there is no carry between lanes.
- On an accepted beat:
  - Each lane updates.
  - out_err[k] |= overflow[k].
  - out_count increments, saturating at all-ones.
  - IDLE goes to ACC.
  - If in_last is set, go to DONE, from either IDLE or ACC.
- DONE: out_valid=1, and out_data/out_err/out_count are frozen. On out_valid && out_ready, return to IDLE and clear the accumulator, out_err and out_count.
- clr in IDLE/ACC:
  - Next state IDLE; accumulator, out_err and out_count cleared.
  - No beat is accepted that cycle, because in_ready is low.
  - clr is ignored in DONE.
- Simultaneous events: in DONE, an out handshake and in_valid in the same cycle. The beat is not accepted, because in_ready=0 that cycle; it is accepted in the following cycle from IDLE.
- Asserting rst_n low mid-burst or in DONE immediately forces all reset values, with no output handshake completing.

## Timing
- Accumulator, flags and count update on the rising edge at which the beat is accepted.
- out_valid rises the cycle after the last beat is accepted. Latency is one cycle, including single-beat bursts.
- out_valid, once high, stays high with stable data until out_ready is sampled high.
- Throughput: one beat per cycle within a burst. There is a minimum one-cycle bubble between bursts, for the DONE handshake.
- in_ready is combinational from state and clr. There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- PSA_ACC_SATCNT_EN defined:
  - sat_cnt[4k+3:4k] increments on each accepted beat in which lane k overflows, saturating at 15.
  - It clears with the accumulator: on a completed output handshake, on clr, and on reset.
- PSA_ACC_SATCNT_EN undefined: no counter logic; sat_cnt is constant 16'h0000.

## Test plan
- Basic sum: 0x1111 three times, last on the third beat, out_ready=1.
  - Required: out_valid one cycle after the third beat, out_data=0x3333, out_err=0, out_count=3.
- Positive saturation: 0x7777 then 0x1111 (last).
  - Required: out_data=0x7777, out_err=4'hF; sat_cnt=0x1111 with the macro, 0x0000 without.
- Negative saturation: 0x8888 then 0xFFFF (last).
  - Required: out_data=0x8888, out_err=4'hF.
- Mixed lanes: 0x7F81 then 0x1111 (last).
  - Required: out_data=0x7092, out_err=4'b1000.
- Backpressure and bubble: single beat 0x0123 (last) with out_ready low for 5 cycles.
  - Required: out_data=0x0123 held stable, in_ready=0 throughout.
  - After out_ready is raised: handshake completes, next cycle in_ready=1 with accumulator 0.
- Abort and reset: clr asserted after two beats of 0x2222.
  - Required: next burst 0x0001 (last) yields 0x0001, out_count=1.
  - rst_n pulsed low in DONE drops out_valid immediately, with all outputs 0.
